// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the FFT peak finder.
// Provides the FSM state enum, default widths and the window-sum width helper.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } fft_peak_state_e;

  localparam int FFT_ADDR_W = 10;
  localparam int FFT_DATA_W = 16;

  // data_w + clog2(win_len) + 1
  function automatic int sum_width(input int data_w, input int win_len);
    int b;
    b = 0;
    while ((1 << b) < win_len) b++;
    return data_w + b + 1;
  endfunction

endpackage

// File: rtl/fft_window_sum.sv
// fft_window_sum: WIN_LEN-deep sample shift register with running sum.
// Ports: clk, rst_n, i_clr, i_valid, i_data -> o_sum, o_full (fill >= WIN_LEN).
module fft_window_sum
  import fft_pkg::*;
#(
  parameter int DATA_W  = FFT_DATA_W,
  parameter int WIN_LEN = 2,
  parameter int SUM_W   = sum_width(DATA_W, WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_full
);

  localparam int FILL_W = $clog2(WIN_LEN + 1);

  logic [DATA_W-1:0] r_win [WIN_LEN];
  logic [SUM_W-1:0]  r_sum;
  logic [FILL_W-1:0] r_fill;
  logic [SUM_W-1:0]  w_in;
  logic [SUM_W-1:0]  w_out;

  assign w_in  = SUM_W'(i_data);
  // oldest sample leaves the window as the new one enters
  assign w_out = SUM_W'(r_win[WIN_LEN-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_fill <= '0;
      for (int i = 0; i < WIN_LEN; i++) r_win[i] <= '0;
    end else if (i_clr) begin
      r_sum  <= '0;
      r_fill <= '0;
      for (int i = 0; i < WIN_LEN; i++) r_win[i] <= '0;
    end else if (i_valid) begin
      r_sum    <= r_sum + w_in - w_out;
      r_win[0] <= i_data;
      for (int i = 1; i < WIN_LEN; i++) r_win[i] <= r_win[i-1];
      if (r_fill != FILL_W'(WIN_LEN)) r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign o_sum  = r_sum;
  assign o_full = (r_fill == FILL_W'(WIN_LEN));

endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: sweeps RAM buckets cfg_lo..cfg_hi, reports the strongest
// WIN_LEN-wide window. Ports: clk, rst_n, i_start, i_cfg_lo/hi/thresh,
// RAM port o_rd_addr/o_rd_en/i_rd_data, o_busy, o_done, o_peak_bucket/sum/valid.
// Macro FFT_PEAK_SECOND_EN adds o_second_bucket/o_second_sum (runner-up window).
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int  DATA_W  = FFT_DATA_W,
  parameter int  ADDR_W  = FFT_ADDR_W,
  parameter int  WIN_LEN = 2,
  parameter int  RD_LAT  = 1,
  localparam int SUM_W   = sum_width(DATA_W, WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_cfg_lo,
  input  logic [ADDR_W-1:0] i_cfg_hi,
  input  logic [SUM_W-1:0]  i_cfg_thresh,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_peak_bucket,
  output logic [SUM_W-1:0]  o_peak_sum,
`ifdef FFT_PEAK_SECOND_EN
  output logic [ADDR_W-1:0] o_second_bucket,
  output logic [SUM_W-1:0]  o_second_sum,
`endif
  output logic              o_peak_valid
);

  localparam int AW1 = ADDR_W + 1;

  fft_peak_state_e   r_state;
  logic [ADDR_W-1:0] r_hi;
  logic [SUM_W-1:0]  r_thresh;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_drain;
  logic [ADDR_W-1:0] r_peak_bucket;
  logic [SUM_W-1:0]  r_peak_sum;
  logic              r_peak_valid;

  logic              r_tag_v [RD_LAT];
  logic [ADDR_W-1:0] r_tag_a [RD_LAT];
  logic              r_cand_v;
  logic [ADDR_W-1:0] r_cand_a;
  logic [SUM_W-1:0]  r_best_sum;
  logic [ADDR_W-1:0] r_best_idx;

  logic [SUM_W-1:0]  w_best_sum_nx;
  logic [ADDR_W-1:0] w_best_idx_nx;
  logic [SUM_W-1:0]  w_win_sum;
  logic              w_win_full;
  logic              w_ret_v;
  logic [ADDR_W-1:0] w_ret_a;
  logic              w_cand;
  logic              w_gt;
  logic              w_last;
  logic              w_pv;

  // widened compare so hi = 2**ADDR_W-1 ends the sweep without wrapping
  assign w_last = (AW1'(r_rd_addr) + AW1'(1)) > AW1'(r_hi);

  // tag pipeline tracks each read until its data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_a[i] <= '0;
      end
    end else if (i_start) begin
      for (int i = 0; i < RD_LAT; i++) r_tag_v[i] <= 1'b0;
    end else begin
      r_tag_v[0] <= r_rd_en;
      r_tag_a[0] <= r_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_a[i] <= r_tag_a[i-1];
      end
    end
  end

  assign w_ret_v = r_tag_v[RD_LAT-1];
  assign w_ret_a = r_tag_a[RD_LAT-1];

  fft_window_sum #(
    .DATA_W (DATA_W),
    .WIN_LEN(WIN_LEN),
    .SUM_W  (SUM_W)
  ) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (i_start),
    .i_valid(w_ret_v),
    .i_data (i_rd_data),
    .o_sum  (w_win_sum),
    .o_full (w_win_full)
  );

  // window sum lands one cycle after its sample; cand tag follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_v <= 1'b0;
      r_cand_a <= '0;
    end else begin
      r_cand_v <= w_ret_v & ~i_start;
      r_cand_a <= w_ret_a;
    end
  end

  assign w_cand = r_cand_v & w_win_full;
  // strict compare keeps the lowest index on ties
  assign w_gt   = w_cand && (w_win_sum > r_best_sum);

  always_comb begin
    w_best_sum_nx = r_best_sum;
    w_best_idx_nx = r_best_idx;
    if (w_gt) begin
      w_best_sum_nx = w_win_sum;
      w_best_idx_nx = r_cand_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_sum <= '0;
      r_best_idx <= '0;
    end else if (i_start) begin
      r_best_sum <= '0;
      r_best_idx <= '0;
    end else begin
      r_best_sum <= w_best_sum_nx;
      r_best_idx <= w_best_idx_nx;
    end
  end

  assign w_pv = w_best_sum_nx > r_thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_hi          <= '0;
      r_thresh      <= '0;
      r_rd_addr     <= '0;
      r_rd_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_drain       <= '0;
      r_peak_bucket <= '0;
      r_peak_sum    <= '0;
      r_peak_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // FINISH publishes the result; a start here still restarts below
      if (r_state == FINISH) begin
        r_done        <= 1'b1;
        r_busy        <= 1'b0;
        r_state       <= IDLE;
        r_peak_sum    <= w_best_sum_nx;
        r_peak_valid  <= w_pv;
        r_peak_bucket <= w_pv ? w_best_idx_nx : '0;
      end
      if (i_start) begin
        r_hi      <= i_cfg_hi;
        r_thresh  <= i_cfg_thresh;
        r_rd_addr <= i_cfg_lo;
        r_busy    <= 1'b1;
        if (i_cfg_hi < i_cfg_lo) begin
          r_state <= FINISH;
          r_rd_en <= 1'b0;
        end else begin
          r_state <= ISSUE;
          r_rd_en <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ISSUE: begin
            if (w_last) begin
              r_state <= DRAIN;
              r_rd_en <= 1'b0;
              r_drain <= 2'(RD_LAT - 1);
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
          DRAIN: begin
            if (r_drain == '0) r_state <= FINISH;
            else r_drain <= r_drain - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rd_addr     = r_rd_addr;
  assign o_rd_en       = r_rd_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_peak_bucket = r_peak_bucket;
  assign o_peak_sum    = r_peak_sum;
  assign o_peak_valid  = r_peak_valid;

`ifdef FFT_PEAK_SECOND_EN
  logic [SUM_W-1:0]  r_sec_sum;
  logic [ADDR_W-1:0] r_sec_idx;
  logic [SUM_W-1:0]  w_sec_sum_nx;
  logic [ADDR_W-1:0] w_sec_idx_nx;
  logic [SUM_W-1:0]  r_second_sum;
  logic [ADDR_W-1:0] r_second_bucket;
  logic              w_far;

  // buckets arrive in increasing order, so cand >= best index
  assign w_far = AW1'(r_cand_a) >= (AW1'(r_best_idx) + AW1'(WIN_LEN));

  always_comb begin
    w_sec_sum_nx = r_sec_sum;
    w_sec_idx_nx = r_sec_idx;
    if (w_gt) begin
      if (w_far) begin
        w_sec_sum_nx = r_best_sum;
        w_sec_idx_nx = r_best_idx;
      end
    end else if (w_cand && w_far && (w_win_sum > r_sec_sum)) begin
      w_sec_sum_nx = w_win_sum;
      w_sec_idx_nx = r_cand_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_sum <= '0;
      r_sec_idx <= '0;
    end else if (i_start) begin
      r_sec_sum <= '0;
      r_sec_idx <= '0;
    end else begin
      r_sec_sum <= w_sec_sum_nx;
      r_sec_idx <= w_sec_idx_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_second_sum    <= '0;
      r_second_bucket <= '0;
    end else if (r_state == FINISH) begin
      r_second_sum    <= w_sec_sum_nx;
      r_second_bucket <= (w_sec_sum_nx > r_thresh) ? w_sec_idx_nx : '0;
    end
  end

  assign o_second_sum    = r_second_sum;
  assign o_second_bucket = r_second_bucket;
`endif

endmodule
